// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery modular-exponentiation sequencer.
// Holds the sequencer state encoding, the multiplier operation encoding and
// the helper that sizes the exponent bit index.
package montgomery_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    NEXT    = 3'd2,
    ISSUE   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Montgomery product kinds: square, multiply by base, convert out (times 1).
  typedef enum logic [1:0] {
    SQR  = 2'd0,
    MUL  = 2'd1,
    CONV = 2'd2
  } op_e;

  // Width of the exponent bit index; never narrower than one bit.
  function automatic int idx_width(input int e_bits);
    if (e_bits > 1) begin
      return $clog2(e_bits);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mmm_req_port.sv
// Four-phase start/done handshake toward one Montgomery multiplier.
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   req_i, a_i, b_i      : request from the sequencer with the operands to launch
//   ack_o, rsp_o         : product available this cycle, and its value
//   idle_o               : start is low and the multiplier has dropped done
//   mmm_start_o/a_o/b_o  : registered start and held operands to the multiplier
//   mmm_p_i, mmm_done_i  : multiplier product and done level
module mmm_req_port #(
  parameter int K_BITS = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [K_BITS-1:0] a_i,
  input  logic [K_BITS-1:0] b_i,
  output logic              ack_o,
  output logic [K_BITS-1:0] rsp_o,
  output logic              idle_o,
  output logic              mmm_start_o,
  output logic [K_BITS-1:0] mmm_a_o,
  output logic [K_BITS-1:0] mmm_b_o,
  input  logic [K_BITS-1:0] mmm_p_i,
  input  logic              mmm_done_i
);

  logic              start_q, start_d;
  logic [K_BITS-1:0] a_q, a_d;
  logic [K_BITS-1:0] b_q, b_d;

  // Launch only into an idle multiplier; hold start and operands until done.
  always_comb begin
    start_d = start_q;
    a_d     = a_q;
    b_d     = b_q;
    if (!start_q) begin
      if (req_i && !mmm_done_i) begin
        start_d = 1'b1;
        a_d     = a_i;
        b_d     = b_i;
      end else begin
        start_d = 1'b0;
      end
    end else begin
      if (mmm_done_i) begin
        start_d = 1'b0;
      end else begin
        start_d = 1'b1;
      end
    end
  end

  // Handshake registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign ack_o       = start_q & mmm_done_i;
  assign rsp_o       = mmm_p_i;
  assign idle_o      = ~start_q & ~mmm_done_i;
  assign mmm_start_o = start_q;
  assign mmm_a_o     = a_q;
  assign mmm_b_o     = b_q;

endmodule

// File: rtl/montgomery_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer around one Montgomery multiplier.
// Ports:
//   i_Clk, i_Rst_n                      : clock, synchronous active-low reset
//   i_Start                             : host start, sampled in IDLE only
//   i_Base_Mont, i_One_Mont, i_Exp, i_m : base*R mod m, R mod m, exponent, modulus
//   o_Result, o_Busy, o_Done            : normal-form result, busy level, done pulse
//   o_Mmm_Start/A/B/m, i_Mmm_P/Done     : multiplier handshake and operands
module montgomery_modexp_ctrl
  import montgomery_pkg::*;
#(
  parameter int K_BITS = 256,
  parameter int E_BITS = 256
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic [K_BITS-1:0] i_Base_Mont,
  input  logic [K_BITS-1:0] i_One_Mont,
  input  logic [E_BITS-1:0] i_Exp,
  input  logic [K_BITS-1:0] i_m,
  output logic [K_BITS-1:0] o_Result,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Mmm_Start,
  output logic [K_BITS-1:0] o_Mmm_A,
  output logic [K_BITS-1:0] o_Mmm_B,
  output logic [K_BITS-1:0] o_Mmm_m,
  input  logic [K_BITS-1:0] i_Mmm_P,
  input  logic              i_Mmm_Done
);

  localparam int IW = idx_width(E_BITS);
  localparam logic [IW-1:0] IDX_TOP = IW'(E_BITS - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [K_BITS-1:0] x_q, x_d;
  logic [E_BITS-1:0] e_q, e_d;
  logic [K_BITS-1:0] base_q, base_d;
  logic [K_BITS-1:0] one_q, one_d;
  logic [K_BITS-1:0] m_q, m_d;
  logic [K_BITS-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              req_s, ack_s, idle_s;
  logic [K_BITS-1:0] rsp_s, opa_s, opb_s;

  // Scan/schedule next-state logic and operand selection.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    x_d     = x_q;
    e_d     = e_q;
    base_d  = base_q;
    one_d   = one_q;
    m_d     = m_q;
    case (state_q)
      IDLE: begin
        if (i_Start) begin
          e_d     = i_Exp;
          base_d  = i_Base_Mont;
          one_d   = i_One_Mont;
          m_d     = i_m;
          idx_d   = IDX_TOP;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (e_q[idx_q]) begin
          // Top set bit: the running value starts as the base itself.
          x_d     = base_q;
          state_d = NEXT;
        end else if (idx_q == '0) begin
          // e = 0: the answer is 1, obtained by converting R mod m out.
          x_d     = one_q;
          op_d    = CONV;
          state_d = ISSUE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      NEXT: begin
        if (idx_q == '0) begin
          op_d = CONV;
        end else begin
          idx_d = idx_q - IW'(1);
          op_d  = SQR;
        end
        state_d = ISSUE;
      end
      ISSUE: begin
        if (ack_s) begin
          x_d     = rsp_s;
          state_d = RELEASE;
        end else begin
          state_d = ISSUE;
        end
      end
      RELEASE: begin
        if (idle_s) begin
          case (op_q)
            SQR: begin
              if (e_q[idx_q]) begin
                op_d    = MUL;
                state_d = ISSUE;
              end else begin
                state_d = NEXT;
              end
            end
            MUL:     state_d = NEXT;
            CONV:    state_d = DONE;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = RELEASE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Operands follow the op being entered so start and data launch together.
    opa_s = x_d;
    case (op_d)
      SQR:     opb_s = x_d;
      MUL:     opb_s = base_q;
      CONV:    opb_s = {{(K_BITS-1){1'b0}}, 1'b1};
      default: opb_s = '0;
    endcase
    req_s = (state_d == ISSUE);

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d == DONE) begin
      result_d = x_q;
    end else begin
      result_d = result_q;
    end
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      op_q     <= SQR;
      idx_q    <= '0;
      x_q      <= '0;
      e_q      <= '0;
      base_q   <= '0;
      one_q    <= '0;
      m_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      e_q      <= e_d;
      base_q   <= base_d;
      one_q    <= one_d;
      m_q      <= m_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  mmm_req_port #(.K_BITS(K_BITS)) u_req_port (
    .clk_i       (i_Clk),
    .rst_ni      (i_Rst_n),
    .req_i       (req_s),
    .a_i         (opa_s),
    .b_i         (opb_s),
    .ack_o       (ack_s),
    .rsp_o       (rsp_s),
    .idle_o      (idle_s),
    .mmm_start_o (o_Mmm_Start),
    .mmm_a_o     (o_Mmm_A),
    .mmm_b_o     (o_Mmm_B),
    .mmm_p_i     (i_Mmm_P),
    .mmm_done_i  (i_Mmm_Done)
  );

  assign o_Result = result_q;
  assign o_Busy   = busy_q;
  assign o_Done   = done_q;
  assign o_Mmm_m  = m_q;

endmodule

// File: tb/tb_montgomery_modexp_ctrl.sv
// Bench for montgomery_modexp_ctrl with K_BITS=8, E_BITS=8 and a behavioural
// Montgomery multiplier (latency K_BITS+2, done held until start drops).
module tb_montgomery_modexp_ctrl;

  localparam int K = 8;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_Start = 1'b0;
  logic [K-1:0] i_Base_Mont = '0;
  logic [K-1:0] i_One_Mont = '0;
  logic [E-1:0] i_Exp = '0;
  logic [K-1:0] i_m = '0;
  logic [K-1:0] o_Result, o_Mmm_A, o_Mmm_B, o_Mmm_m;
  logic         o_Busy, o_Done, o_Mmm_Start;
  logic [K-1:0] mm_p = '0;
  logic         mm_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int start_rises = 0, hold_err = 0, m_err = 0, early_err = 0;
  int cur_m = 13;

  always #5 clk = ~clk;

  montgomery_modexp_ctrl #(.K_BITS(K), .E_BITS(E)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(i_Start),
    .i_Base_Mont(i_Base_Mont), .i_One_Mont(i_One_Mont), .i_Exp(i_Exp), .i_m(i_m),
    .o_Result(o_Result), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_Mmm_Start(o_Mmm_Start), .o_Mmm_A(o_Mmm_A), .o_Mmm_B(o_Mmm_B), .o_Mmm_m(o_Mmm_m),
    .i_Mmm_P(mm_p), .i_Mmm_Done(mm_done)
  );

  // a*b*R^-1 mod m with R = 2^K
  function automatic int mont(input int a, input int b, input int m);
    int rinv = 0;
    for (int r = 1; r < m; r++) if (((256 * r) % m) == 1) rinv = r;
    return (((a * b) % m) * rinv) % m;
  endfunction

  function automatic int pow_mod(input int b, input int ex, input int m);
    int r = 1 % m;
    for (int i = 0; i < ex; i++) r = (r * b) % m;
    return r;
  endfunction

  function automatic int top_bit(input int ex);
    int t = -1;
    for (int i = 0; i < E; i++) if (((ex >> i) & 1) == 1) t = i;
    return t;
  endfunction

  function automatic int n_ops(input int ex);
    if (ex == 0) return 1;
    return top_bit(ex) + $countones(ex[E-1:0]);
  endfunction

  function automatic int first_lat(input int ex);
    return (E - 1 - top_bit(ex)) + 2;
  endfunction

  // Behavioural multiplier.
  logic         mm_busy = 1'b0;
  int           mm_cnt = 0;
  logic [K-1:0] mm_a = '0, mm_b = '0;
  always @(posedge clk) begin
    if (!rst_n) begin
      mm_done <= 1'b0; mm_busy <= 1'b0; mm_cnt <= 0; mm_p <= '0;
    end else if (mm_busy) begin
      if (mm_cnt == K + 1) begin
        mm_busy <= 1'b0; mm_done <= 1'b1; mm_p <= K'(mont(int'(mm_a), int'(mm_b), cur_m));
      end else mm_cnt <= mm_cnt + 1;
    end else if (mm_done) begin
      if (!o_Mmm_Start) mm_done <= 1'b0;
    end else if (o_Mmm_Start) begin
      mm_busy <= 1'b1; mm_cnt <= 1; mm_a <= o_Mmm_A; mm_b <= o_Mmm_B;
    end
  end

  // Handshake monitor: counts launches and protocol violations.
  logic         prev_start = 1'b0;
  logic [K-1:0] prev_a = '0, prev_b = '0;
  always @(negedge clk) begin
    if (o_Mmm_Start && !prev_start) begin
      start_rises <= start_rises + 1;
      if (mm_done) early_err <= early_err + 1;
    end
    if (o_Mmm_Start && prev_start && (o_Mmm_A !== prev_a || o_Mmm_B !== prev_b)) hold_err <= hold_err + 1;
    if (o_Busy && o_Mmm_m !== K'(cur_m)) m_err <= m_err + 1;
    prev_start <= o_Mmm_Start; prev_a <= o_Mmm_A; prev_b <= o_Mmm_B;
  end

  // One exponentiation, starting at a negedge; returns observations.
  task automatic run_op(input int base, input int ex, input int m, input int inj,
                        output int res, output int ops, output int lat, output bit tmo,
                        output bit busy_first, output bit done_after, output bit busy_after);
    int c, r0;
    cur_m = m;
    i_Base_Mont = K'((base * 256) % m); i_One_Mont = K'(256 % m);
    i_Exp = E'(ex); i_m = K'(m); i_Start = 1'b1;
    r0 = start_rises;
    @(negedge clk);
    i_Start = 1'b0; c = 0; busy_first = o_Busy; lat = -1; tmo = 1'b0;
    while (o_Done !== 1'b1) begin
      if (c >= 4000) begin tmo = 1'b1; break; end
      @(negedge clk); c++;
      if (inj > 0 && c == inj) begin
        i_Start = 1'b1; i_Exp = 8'h03; i_Base_Mont = 8'h01; i_m = 8'd7;
      end else if (inj > 0 && c == inj + 1) begin
        i_Start = 1'b0;
      end
      if (lat < 0 && o_Mmm_Start === 1'b1) lat = c;
    end
    res = int'(o_Result); ops = start_rises - r0;
    @(negedge clk);
    done_after = o_Done; busy_after = o_Busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_Result !== 8'd0 || o_Busy !== 1'b0 || o_Done !== 1'b0) begin
      errors++; $display("FAIL reset_status: result=%0d busy=%b done=%b, required 0/0/0", o_Result, o_Busy, o_Done); end
    checks++; if (o_Mmm_Start !== 1'b0 || o_Mmm_A !== 8'd0 || o_Mmm_B !== 8'd0 || o_Mmm_m !== 8'd0) begin
      errors++; $display("FAIL reset_mmm: start=%b a=%0d b=%0d m=%0d, required all 0", o_Mmm_Start, o_Mmm_A, o_Mmm_B, o_Mmm_m); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_base_case();
    int res, ops, lat; bit tmo, bf, da, ba;
    run_op(2, 5, 13, 0, res, ops, lat, tmo, bf, da, ba);
    checks++; if (tmo || res !== 6) begin errors++; $display("FAIL base_result: got %0d timeout=%b, required 6", res, tmo); end
    checks++; if (ops !== 4) begin errors++; $display("FAIL base_ops: got %0d, required 4", ops); end
    checks++; if (lat !== first_lat(5)) begin errors++; $display("FAIL base_latency: got %0d, required %0d", lat, first_lat(5)); end
    checks++; if (bf !== 1'b1) begin errors++; $display("FAIL base_busy_rise: got %b, required 1", bf); end
    checks++; if (da !== 1'b0 || ba !== 1'b0) begin errors++; $display("FAIL base_done_width: done=%b busy=%b after pulse, required 0/0", da, ba); end
  endtask

  task automatic test_zero_exp();
    int res, ops, lat; bit tmo, bf, da, ba;
    run_op(2, 0, 13, 0, res, ops, lat, tmo, bf, da, ba);
    checks++; if (tmo || res !== 1) begin errors++; $display("FAIL zero_result: got %0d timeout=%b, required 1", res, tmo); end
    checks++; if (ops !== 1) begin errors++; $display("FAIL zero_ops: got %0d, required 1", ops); end
  endtask

  task automatic test_all_ones();
    int res, ops, lat; bit tmo, bf, da, ba;
    run_op(2, 255, 13, 0, res, ops, lat, tmo, bf, da, ba);
    checks++; if (tmo || res !== 8) begin errors++; $display("FAIL ones_result: got %0d timeout=%b, required 8", res, tmo); end
    checks++; if (ops !== 15) begin errors++; $display("FAIL ones_ops: got %0d, required 15", ops); end
  endtask

  task automatic test_e_one();
    int res, ops, lat; bit tmo, bf, da, ba;
    run_op(2, 1, 13, 0, res, ops, lat, tmo, bf, da, ba);
    checks++; if (tmo || res !== 2) begin errors++; $display("FAIL eone_result: got %0d timeout=%b, required 2", res, tmo); end
    checks++; if (ops !== 1) begin errors++; $display("FAIL eone_ops: got %0d, required 1", ops); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL eone_latency: got %0d, required 9", lat); end
  endtask

  task automatic test_start_while_busy();
    int res, ops, lat; bit tmo, bf, da, ba;
    run_op(2, 255, 13, 30, res, ops, lat, tmo, bf, da, ba);
    checks++; if (tmo || res !== 8 || ops !== 15) begin
      errors++; $display("FAIL busy_ignore: got result %0d ops %0d, required 8 and 15", res, ops); end
    // issued right after the done pulse
    run_op(2, 5, 13, 0, res, ops, lat, tmo, bf, da, ba);
    checks++; if (tmo || res !== 6 || ops !== 4) begin
      errors++; $display("FAIL back_to_back: got result %0d ops %0d, required 6 and 4", res, ops); end
  endtask

  task automatic test_random();
    int res, ops, lat, m, b, ex; bit tmo, bf, da, ba;
    for (int n = 0; n < 20; n++) begin
      m = 2 * int'($urandom_range(1, 127)) + 1;
      b = int'($urandom_range(0, m - 1));
      ex = int'($urandom_range(0, 255));
      run_op(b, ex, m, 0, res, ops, lat, tmo, bf, da, ba);
      checks++; if (tmo || res !== pow_mod(b, ex, m)) begin
        errors++; $display("FAIL rand_result: b=%0d e=%0d m=%0d got %0d, required %0d", b, ex, m, res, pow_mod(b, ex, m)); end
      checks++; if (ops !== n_ops(ex)) begin
        errors++; $display("FAIL rand_ops: e=%0d got %0d, required %0d", ex, ops, n_ops(ex)); end
      if (ex != 0) begin
        checks++; if (lat !== first_lat(ex)) begin
          errors++; $display("FAIL rand_latency: e=%0d got %0d, required %0d", ex, lat, first_lat(ex)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int res, ops, lat, c; bit tmo, bf, da, ba;
    run_op(2, 5, 13, 0, res, ops, lat, tmo, bf, da, ba);
    cur_m = 13; i_Base_Mont = 8'd5; i_One_Mont = 8'd9; i_Exp = 8'hFF; i_m = 8'd13; i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0; c = 0;
    while (o_Mmm_Start !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    checks++; if (o_Mmm_Start !== 1'b1) begin errors++; $display("FAIL rstmid_issue: start=%b, required 1", o_Mmm_Start); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (o_Busy !== 1'b0 || o_Mmm_Start !== 1'b0 || o_Result !== 8'd0 || o_Done !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: busy=%b start=%b result=%0d done=%b, required 0/0/0/0", o_Busy, o_Mmm_Start, o_Result, o_Done); end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3, 7, 13, 0, res, ops, lat, tmo, bf, da, ba);
    checks++; if (tmo || res !== 3 || ops !== 5) begin
      errors++; $display("FAIL rstmid_rerun: got result %0d ops %0d, required 3 and 5", res, ops); end
  endtask

  task automatic test_protocol();
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL operand_hold: %0d unstable cycles, required 0", hold_err); end
    checks++; if (m_err !== 0) begin errors++; $display("FAIL modulus_out: %0d wrong cycles, required 0", m_err); end
    checks++; if (early_err !== 0) begin errors++; $display("FAIL start_vs_done: %0d launches while done high, required 0", early_err); end
  endtask

  initial begin
    test_reset();
    test_base_case();
    test_zero_exp();
    test_all_ones();
    test_e_one();
    test_start_while_busy();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
